// File: rtl/comb_filter_mc.sv
`default_nettype none
// ============================================================================
// comb_filter_mc : multi-channel saturating feedback comb; one shared delay RAM
//                  time-multiplexed across channels. Optional COMB_DAMP_EN adds
//                  a one-pole damping filter in the feedback path.
// Revision 1.0
// ============================================================================
module comb_filter_mc #(
  parameter int DATA_W    = 32,
  parameter int MAX_DEPTH = 2048,
  parameter int CHANNELS  = 2,
  parameter int GAIN_W    = 8,
  localparam int ADDR_W   = $clog2(MAX_DEPTH),
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef COMB_DAMP_EN
  input  logic [GAIN_W-1:0]            damp_i,
`endif
  input  logic                         enable_i,
  input  logic [ADDR_W:0]              delay_len_i,
  input  logic [GAIN_W-1:0]            fb_gain_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [CHANNELS*DATA_W-1:0]   in_data_i,
  output logic                         out_valid_o,
  output logic [CHANNELS*DATA_W-1:0]   out_data_o
);

  localparam int EXT_W     = DATA_W + GAIN_W + 2;
  localparam int RAM_AW    = CH_W + ADDR_W;
  localparam int RAM_DEPTH = CHANNELS * MAX_DEPTH;

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_PROC   = 3'd2;
  localparam logic [2:0] S_BYPASS = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [RAM_AW-1:0] CLR_LAST = RAM_AW'(RAM_DEPTH - 1);
  localparam logic [ADDR_W:0]   DL_MAX   = (ADDR_W+1)'(MAX_DEPTH);
  localparam logic [ADDR_W:0]   DL_ONE   = (ADDR_W+1)'(1);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [EXT_W-1:0] sext(input logic [DATA_W-1:0] v);
    return $signed({{(EXT_W-DATA_W){v[DATA_W-1]}}, v});
  endfunction

  function automatic logic signed [EXT_W-1:0] mul_shift(input logic signed [EXT_W-1:0] a,
                                                        input logic [GAIN_W-1:0]       g);
    logic signed [EXT_W-1:0] gx;
    gx = $signed({{(EXT_W-GAIN_W){1'b0}}, g});
    return (a * gx) >>> GAIN_W;
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [EXT_W-1:0] x);
    if (x > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return x[DATA_W-1:0];
  endfunction

  logic [2:0]                   state_q, state_d;
  logic [RAM_AW-1:0]            clr_q;
  logic [CH_W-1:0]              ch_q;
  logic [ADDR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]              dl_q, dl_clamped;
  logic [GAIN_W-1:0]            gain_q;
  logic                         en_q;
  logic [CHANNELS*DATA_W-1:0]   frame_q;
  logic                         out_valid_q;
  logic [CHANNELS*DATA_W-1:0]   out_data_q;

  logic [DATA_W-1:0]            ram [RAM_DEPTH];
  logic [DATA_W-1:0]            rd_q;
  logic                         ram_we;
  logic [RAM_AW-1:0]            ram_wa, ram_ra;
  logic [DATA_W-1:0]            ram_wd;

  logic [DATA_W-1:0]            ch_sample, fb_src, proc_val;

`ifdef COMB_DAMP_EN
  logic [DATA_W-1:0]            lp_q [CHANNELS];
  logic [GAIN_W-1:0]            damp_q;
  logic [DATA_W-1:0]            lp_new;
`endif

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_comb begin
    if (delay_len_i == '0)        dl_clamped = DL_ONE;
    else if (delay_len_i > DL_MAX) dl_clamped = DL_MAX;
    else                           dl_clamped = delay_len_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:  if (clr_q == CLR_LAST) state_d = S_IDLE;
      S_IDLE:   if (in_valid_i) state_d = enable_i ? S_PROC : S_BYPASS;
      S_PROC:   if (ch_q == CH_LAST) state_d = S_DONE;
      S_BYPASS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_CLEAR;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (state_q == S_IDLE && in_valid_i && !enable_i)
      wr_ptr_d = '0;
    else if (state_q == S_DONE && en_q)
      wr_ptr_d = ({1'b0, wr_ptr_q} >= dl_q - DL_ONE) ? '0 : wr_ptr_q + 1'b1;
  end

  always_comb begin
    ch_sample = frame_q[ch_q*DATA_W +: DATA_W];
`ifdef COMB_DAMP_EN
    lp_new = sat(sext(rd_q) + mul_shift(sext(lp_q[ch_q]) - sext(rd_q), damp_q));
    fb_src = lp_new;
`else
    fb_src = rd_q;
`endif
    proc_val = sat((sext(ch_sample) >>> 1) + mul_shift(sext(fb_src), gain_q));
  end

  // Read runs one channel ahead of the write so each channel takes one cycle;
  // channel 0 is fetched on the accept edge.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = clr_q;
    ram_wd = '0;
    ram_ra = {CH_W'(0), wr_ptr_q};
    case (state_q)
      S_CLEAR: ram_we = 1'b1;
      S_PROC: begin
        ram_we = 1'b1;
        ram_wa = {ch_q, wr_ptr_q};
        ram_wd = proc_val;
        if (ch_q != CH_LAST) ram_ra = {ch_q + CH_W'(1), wr_ptr_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    rd_q <= ram[ram_ra];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CLEAR;
      clr_q       <= '0;
      ch_q        <= '0;
      wr_ptr_q    <= '0;
      dl_q        <= '0;
      gain_q      <= '0;
      en_q        <= 1'b0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      out_valid_q <= (state_q == S_DONE);
      case (state_q)
        S_CLEAR: clr_q <= (clr_q == CLR_LAST) ? '0 : clr_q + 1'b1;
        S_IDLE: begin
          if (in_valid_i) begin
            frame_q <= in_data_i;
            gain_q  <= fb_gain_i;
            dl_q    <= dl_clamped;
            en_q    <= enable_i;
            ch_q    <= '0;
          end
        end
        S_PROC: begin
          out_data_q[ch_q*DATA_W +: DATA_W] <= rd_q;
          ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
        end
        S_BYPASS: out_data_q <= frame_q;
        default: ;
      endcase
    end
  end

`ifdef COMB_DAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      damp_q <= '0;
      for (int c = 0; c < CHANNELS; c++) lp_q[c] <= '0;
    end else if (state_q == S_CLEAR) begin
      for (int c = 0; c < CHANNELS; c++) lp_q[c] <= '0;
    end else begin
      if (state_q == S_IDLE && in_valid_i) damp_q <= damp_i;
      if (state_q == S_PROC) lp_q[ch_q] <= lp_new;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_comb_filter_mc.sv
`default_nettype none
// ============================================================================
// tb_comb_filter_mc : directed bench for comb_filter_mc with a per-frame
//                     arithmetic model and literal impulse/saturation anchors.
// Revision 1.0
// ============================================================================
module tb_comb_filter_mc;
  localparam int DW = 32;
  localparam int MD = 16;
  localparam int CH = 2;
  localparam int GW = 8;
  localparam longint MAXV = 2147483647;
  localparam longint MINV = -longint'(2147483647) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable_i;
  logic [4:0]      delay_len_i;
  logic [GW-1:0]   fb_gain_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [CH*DW-1:0] in_data_i;
  logic            out_valid_o;
  logic [CH*DW-1:0] out_data_o;

  always #5 clk = ~clk;

  comb_filter_mc #(.DATA_W(DW), .MAX_DEPTH(MD), .CHANNELS(CH), .GAIN_W(GW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef COMB_DAMP_EN
    .damp_i      (8'd0),
`endif
    .enable_i    (enable_i),
    .delay_len_i (delay_len_i),
    .fb_gain_i   (fb_gain_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o)
  );

  typedef struct {
    logic [63:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        expq[$];
  exp_t        cmp_e;
  logic [63:0] obs[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;

  longint mbuf [CH][MD];
  int     mptr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic longint sat32(input longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < MD; i++) mbuf[c][i] = 0;
    mptr = 0;
  endtask

  // Frame-level behaviour: each channel outputs the stored sample, then stores
  // half the input plus the scaled stored sample, clamped to 32-bit range.
  task automatic model_accept(input bit en, input int dl, input int g,
                              input logic [63:0] din, output logic [63:0] dout);
    longint d, x;
    int     dlc;
    dout = din;
    if (!en) begin
      mptr = 0;
      return;
    end
    dlc = (dl == 0) ? 1 : ((dl > MD) ? MD : dl);
    for (int c = 0; c < CH; c++) begin
      d = mbuf[c][mptr];
      dout[c*DW +: DW] = d[DW-1:0];
      x = longint'($signed(din[c*DW +: DW]));
      mbuf[c][mptr] = sat32((x >>> 1) + ((d * g) >>> GW));
    end
    mptr = (mptr >= dlc - 1) ? 0 : mptr + 1;
  endtask

  always @(negedge clk) begin
    if (out_valid_o) begin
      if (expq.size() == 0) begin
        chk("spurious_out_valid", {63'b0, out_valid_o}, 64'd0);
      end else begin
        cmp_e = expq.pop_front();
        chk("out_data", out_data_o, cmp_e.data);
        chk("latency", 64'(cyc - cmp_e.acc), 64'(cmp_e.lat));
        obs.push_back(out_data_o);
      end
    end
  end

  task automatic send(input bit en, input int dl, input int g,
                      input logic [31:0] c0, input logic [31:0] c1, input bit track);
    int   n;
    exp_t e;
    @(negedge clk);
    enable_i    = en;
    delay_len_i = 5'(dl);
    fb_gain_i   = 8'(g);
    in_data_i   = {c1, c0};
    in_valid_i  = 1'b1;
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_o) begin
      chk("accept_timeout", {63'b0, in_ready_o}, 64'd1);
      in_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    if (track) begin
      model_accept(en, dl, g, {c1, c0}, e.data);
      e.acc = cyc;
      e.lat = en ? CH + 1 : 2;
      expq.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(expq.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 64'(n), 64'(CH * MD));
  endtask

  function automatic logic [63:0] obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return 'x;
  endfunction

  function automatic logic [31:0] ch0_at(input int i);
    logic [63:0] v;
    v = obs_at(i);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ch1_at(input int i);
    logic [63:0] v;
    v = obs_at(i);
    return v[63:32];
  endfunction

  task automatic impulse_checks(input string tag);
    chk({tag, "_f0"},  obs_at(0), 64'd0);
    chk({tag, "_f3"},  64'(ch0_at(3)), 64'd0);
    chk({tag, "_f4"},  64'(ch0_at(4)), 64'h0800_0000);
    chk({tag, "_f8"},  64'(ch0_at(8)), 64'h0400_0000);
    chk({tag, "_f12"}, 64'(ch0_at(12)), 64'h0200_0000);
    chk({tag, "_ch1"}, 64'(ch1_at(4)), 64'd0);
  endtask

  initial begin
    bit mono;
    enable_i    = 1'b1;
    delay_len_i = '0;
    fb_gain_i   = '0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {63'b0, in_ready_o}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid_o}, 64'd0);
    chk("rst_out_data",  out_data_o, 64'd0);
    rst_n = 1'b1;
    wait_ready("clear_len_por");

    obs.delete();
    for (int f = 0; f < 15; f++)
      send(1'b1, 4, 128, (f == 0) ? 32'h1000_0000 : 32'h0, 32'h0, 1'b1);
    drain();
    impulse_checks("impulse");

    obs.delete();
    send(1'b0, 4, 128, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    drain();
    chk("bypass_data", obs_at(0), 64'h1234_5678_DEAD_BEEF);

    // A non-reset pointer would land on slot 3, which holds 0.
    obs.delete();
    send(1'b1, 4, 128, 32'h0, 32'h0, 1'b1);
    drain();
    chk("reenable_ptr0", 64'(ch0_at(0)), 64'h0100_0000);

    obs.delete();
    for (int f = 0; f < 10; f++) send(1'b1, 1, 255, 32'h7FFF_FFFF, 32'h0, 1'b1);
    drain();
    mono = 1'b1;
    for (int i = 1; i < obs.size(); i++) begin
      if ($signed(ch0_at(i)) < $signed(ch0_at(i-1))) mono = 1'b0;
      if ($signed(ch0_at(i)) < 0) mono = 1'b0;
    end
    chk("sat_monotonic", {63'b0, mono}, 64'd1);
    chk("sat_pos", 64'(ch0_at(9)), 64'h7FFF_FFFF);

    obs.delete();
    for (int f = 0; f < 12; f++) send(1'b1, 1, 255, 32'h8000_0000, 32'h0, 1'b1);
    drain();
    chk("sat_neg", 64'(ch0_at(11)), 64'h8000_0000);

    obs.delete();
    for (int f = 0; f < 6; f++)
      send(1'b1, 8, 200, 32'h0100_0000 * (f + 1), 32'hF000_0000 + f, 1'b1);
    for (int f = 0; f < 4; f++)
      send(1'b1, 3, 90, 32'h0030_0000 - f, 32'h0A00_0000, 1'b1);
    send(1'b1, 0, 64, 32'h1111_1111, 32'h2222_2222, 1'b1);
    send(1'b1, 31, 0, 32'h3333_3333, 32'hC000_0000, 1'b1);
    drain();
    chk("one_out_per_frame", 64'(obs.size()), 64'd12);
    chk("no_x_out", 64'($isunknown(out_data_o)), 64'd0);

    // Reset asserted while the second channel is being processed.
    send(1'b1, 4, 128, 32'h5555_0000, 32'h1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_out_valid", {63'b0, out_valid_o}, 64'd0);
    end
    model_reset();
    rst_n = 1'b1;
    wait_ready("clear_len_midrst");

    obs.delete();
    for (int f = 0; f < 13; f++)
      send(1'b1, 4, 128, (f == 0) ? 32'h1000_0000 : 32'h0, 32'h0, 1'b1);
    drain();
    impulse_checks("post_rst_impulse");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    chk("global_timeout", 64'd1, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
